me_ctrl: RTL

//  Sequencer for the 8x8-template / 32x32-window SAD PE array, one motion-estimation search per start.

---
 rtl/me_ctrl.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/me_ctrl.sv
// me_ctrl -- sequencer for an 8x8-template / 32x32-window SAD PE array.
// Each search does four things in order:
//   - loads the template into the array;
//   - streams the search window in raster order;
//   - tags every SAD sample from the sum tree with its candidate position;
//   - keeps the running minimum and reports the best motion vector.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    begin a search (honoured only while idle)
//   busy     search in progress
//   done     one-cycle pulse, results valid from this cycle
//   tb_re    template memory read enable
//   tb_addr  template read address
//   sw_re    window memory read enable
//   sw_addr  window read address, row*SW+col
//   en_tb    tb_re delayed one cycle (memory latency)
//   en_sw    sw_re delayed one cycle
//   sad      SAD from the sum tree
//   min_sad  best SAD of the last completed search
//   mv_x     best candidate column offset
//   mv_y     best candidate row offset
//
// All outputs are registered copies of the internal state.
// The visible timing therefore trails the FSM by one cycle:
//   - the internal DONE state is the cycle *before* done is seen;
//   - while done is high the FSM already sits in IDLE.
// start is therefore also blocked while done is high, so the externally
// visible done cycle never accepts a new search.
module me_ctrl #(
    parameter int TB_LENGTH = 8,
    parameter int SW_LENGTH = 32,
    parameter int SAD_LAT   = 2,
    parameter int SAD_W     = 14
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       tb_re,
    output logic [$clog2(TB_LENGTH*TB_LENGTH)-1:0]     tb_addr,
    output logic                                       sw_re,
    output logic [$clog2(SW_LENGTH*SW_LENGTH)-1:0]     sw_addr,
    output logic                                       en_tb,
    output logic                                       en_sw,
    input  logic [SAD_W-1:0]                           sad,
    output logic [SAD_W-1:0]                           min_sad,
    output logic [$clog2(SW_LENGTH-TB_LENGTH+1)-1:0]   mv_x,
    output logic [$clog2(SW_LENGTH-TB_LENGTH+1)-1:0]   mv_y
);

    localparam int TBA = $clog2(TB_LENGTH*TB_LENGTH);
    localparam int SWA = $clog2(SW_LENGTH*SW_LENGTH);
    localparam int SWB = $clog2(SW_LENGTH);
    localparam int MVW = $clog2(SW_LENGTH-TB_LENGTH+1);

    localparam logic [SWA-1:0] CNT_ONE     = SWA'(1);
    localparam logic [SWA-1:0] LOAD_LAST   = SWA'(TB_LENGTH*TB_LENGTH-1);
    localparam logic [SWA-1:0] STREAM_LAST = SWA'(SW_LENGTH*SW_LENGTH-1);
    localparam logic [SWA-1:0] DRAIN_LAST  = SWA'(SAD_LAT);
    localparam logic [SWB-1:0] TB_M1       = SWB'(TB_LENGTH-1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [SWA-1:0]       cnt_r, cnt_nxt_s;
    logic                 start_ok_s;

    logic [SWA-1:0]       k_d_r;
    logic [SWB-1:0]       row_s, col_s;
    logic                 tag_v_s;
    logic [MVW-1:0]       tag_x_s, tag_y_s;

    logic [SAD_LAT-1:0]           pv_r;
    logic [SAD_LAT-1:0][MVW-1:0]  px_r;
    logic [SAD_LAT-1:0][MVW-1:0]  py_r;

    logic [SAD_W-1:0]     run_min_r;
    logic [MVW-1:0]       run_x_r, run_y_r;
    logic                 upd_s;
    logic [SAD_W-1:0]     best_sad_s;
    logic [MVW-1:0]       best_x_s, best_y_s;

    // FSM state and phase counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        start_ok_s  = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = '0;
                // done high means the previous search is still visibly finishing
                if (start && !done) begin
                    state_nxt_s = LOAD;
                    start_ok_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (cnt_r == LOAD_LAST) begin
                    state_nxt_s = STREAM;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            STREAM: begin
                if (cnt_r == STREAM_LAST) begin
                    state_nxt_s = DRAIN;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            DRAIN: begin
                if (cnt_r == DRAIN_LAST) begin
                    state_nxt_s = DONE;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Registered control outputs, memory addresses and PE enables
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            tb_re   <= 1'b0;
            tb_addr <= '0;
            sw_re   <= 1'b0;
            sw_addr <= '0;
            en_tb   <= 1'b0;
            en_sw   <= 1'b0;
            k_d_r   <= '0;
        end else begin
            busy    <= (state_r != IDLE);
            done    <= (state_r == DONE);
            tb_re   <= (state_r == LOAD);
            tb_addr <= (state_r == LOAD) ? cnt_r[TBA-1:0] : '0;
            sw_re   <= (state_r == STREAM);
            sw_addr <= (state_r == STREAM) ? cnt_r : '0;
            en_tb   <= tb_re;
            en_sw   <= sw_re;
            k_d_r   <= sw_addr;
        end
    end

    // Candidate tag for the pel being shifted in by en_sw this cycle
    always_comb begin
        row_s   = k_d_r[SWA-1:SWB];
        col_s   = k_d_r[SWB-1:0];
        tag_v_s = en_sw && (row_s >= TB_M1) && (col_s >= TB_M1);
        tag_x_s = MVW'(col_s - TB_M1);
        tag_y_s = MVW'(row_s - TB_M1);
    end

    // Tag delay line, aligned with the sum-tree latency
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_r <= '0;
            px_r <= '0;
            py_r <= '0;
        end else begin
            pv_r[0] <= tag_v_s;
            px_r[0] <= tag_x_s;
            py_r[0] <= tag_y_s;
            for (int i = 1; i < SAD_LAT; i++) begin
                pv_r[i] <= pv_r[i-1];
                px_r[i] <= px_r[i-1];
                py_r[i] <= py_r[i-1];
            end
        end
    end

    // Strict less-than so ties keep the earlier raster candidate
    always_comb begin
        upd_s      = pv_r[SAD_LAT-1] && (sad < run_min_r);
        best_sad_s = upd_s ? sad : run_min_r;
        best_x_s   = upd_s ? px_r[SAD_LAT-1] : run_x_r;
        best_y_s   = upd_s ? py_r[SAD_LAT-1] : run_y_r;
    end

    // Running minimum, restarted when a search is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            run_min_r <= {SAD_W{1'b1}};
            run_x_r   <= '0;
            run_y_r   <= '0;
        end else if (start_ok_s) begin
            run_min_r <= {SAD_W{1'b1}};
            run_x_r   <= '0;
            run_y_r   <= '0;
        end else begin
            run_min_r <= best_sad_s;
            run_x_r   <= best_x_s;
            run_y_r   <= best_y_s;
        end
    end

    // Published results; the last tagged sample lands in the DONE state, so merge it here
    always_ff @(posedge clk) begin
        if (rst) begin
            min_sad <= {SAD_W{1'b1}};
            mv_x    <= '0;
            mv_y    <= '0;
        end else if (state_r == DONE) begin
            min_sad <= best_sad_s;
            mv_x    <= best_x_s;
            mv_y    <= best_y_s;
        end else begin
            min_sad <= min_sad;
            mv_x    <= mv_x;
            mv_y    <= mv_y;
        end
    end

endmodule
